ir_key_dec: RTL and testbench

Downstream stage of the NEC IR receiver. Takes each completed 32-bit frame and each repeat-code strobe, checks the address and command complement bytes, and optionally filters on the remote address. It emits a one-cycle key event for every accepted press and for each auto-repeat while the key is held. It also tracks key-held state with a timeout. Its outputs feed the FND display path and any key-driven control logic.

---
 rtl/ir_pkg.sv | 28 ++
 rtl/ir_key_dec_if.sv | 25 ++
 rtl/ir_key_dec_tick_gen.sv | 38 +++
 rtl/ir_key_dec.sv | 159 +++++++++++++++
 tb/tb_ir_key_dec.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receive path: FSM encoding, frame byte
// positions and default timing constants used by the receiver and key decoder.
package ir_pkg;

    // Key-tracking FSM encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } ir_state_e;

    // Byte positions inside a 32-bit NEC frame {addr, addr_n, cmd, cmd_n}.
    localparam int NEC_ADDR_LSB   = 24;
    localparam int NEC_ADDR_N_LSB = 16;
    localparam int NEC_CMD_LSB    = 8;
    localparam int NEC_CMD_N_LSB  = 0;

    // Defaults for a 50 MHz system clock and the NEC repeat period.
    localparam int DEF_TICK_DIV   = 50;
    localparam int DEF_HOLD_TO_US = 120000;

    // Width needed to hold max_val, never narrower than min_w.
    function automatic int cnt_width(input int max_val, input int min_w);
        int w;
        w = (max_val > 0) ? $clog2(max_val + 1) : 1;
        return (w > min_w) ? w : min_w;
    endfunction

endpackage

// File: rtl/ir_key_dec_if.sv
// Frame/repeat input bus and key-event output bus of the key decoder.
interface ir_key_dec_if;
    logic [31:0] i_frame;
    logic        i_frame_vld;
    logic        i_rpt;
    logic [7:0]  o_key;
    logic [7:0]  o_addr;
    logic        o_key_vld;
    logic        o_key_rpt;
    logic        o_held;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    // Upstream receiver / stimulus side.
    modport master (
        output i_frame, i_frame_vld, i_rpt,
        input  o_key, o_addr, o_key_vld, o_key_rpt, o_held, o_err, o_err_cnt
    );

    // Key decoder side.
    modport slave (
        input  i_frame, i_frame_vld, i_rpt,
        output o_key, o_addr, o_key_vld, o_key_rpt, o_held, o_err, o_err_cnt
    );
endinterface

// File: rtl/ir_key_dec_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap the prescaler at TICK_DIV-1.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missing
        // assignment on some branch would infer a latch.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/ir_key_dec.sv
// NEC key decoder: validates frames, filters on address, emits press and
// auto-repeat key events, tracks key-held state with a microsecond timeout.
module ir_key_dec
    import ir_pkg::*;
#(
    parameter int         TICK_DIV   = DEF_TICK_DIV,
    parameter int         HOLD_TO_US = DEF_HOLD_TO_US,
    parameter int         RPT_DELAY  = 3,
    parameter bit         ADDR_FILT  = 1'b0,
    parameter logic [7:0] ADDR       = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    ir_key_dec_if.slave  bus
);
    localparam int            TO_W     = cnt_width(HOLD_TO_US, 17);
    localparam int            RC_W     = cnt_width(RPT_DELAY, 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(HOLD_TO_US);
    localparam logic [RC_W-1:0] RC_LIMIT = RC_W'(RPT_DELAY);

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    // Frame field extraction and integrity check.
    logic [7:0] f_addr, f_addr_n, f_cmd, f_cmd_n;
    logic       frame_ok;

    assign f_addr   = bus.i_frame[NEC_ADDR_LSB   +: 8];
    assign f_addr_n = bus.i_frame[NEC_ADDR_N_LSB +: 8];
    assign f_cmd    = bus.i_frame[NEC_CMD_LSB    +: 8];
    assign f_cmd_n  = bus.i_frame[NEC_CMD_N_LSB  +: 8];

    assign frame_ok = ((f_addr ^ f_addr_n) == 8'hFF) &&
                      ((f_cmd  ^ f_cmd_n)  == 8'hFF) &&
                      (!ADDR_FILT || (f_addr == ADDR));

    ir_state_e       state_q, state_d;
    logic [7:0]      key_q, key_d;
    logic [7:0]      addr_q, addr_d;
    logic            key_vld_q, key_vld_d;
    logic            key_rpt_q, key_rpt_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [RC_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Event decode. A frame always wins over a same-cycle repeat strobe.
    logic press, bad, rpt_hit, timeout_hit;

    assign press   = bus.i_frame_vld && frame_ok;
    assign bad     = bus.i_frame_vld && !frame_ok;
    assign rpt_hit = bus.i_rpt && !bus.i_frame_vld && (state_q == ST_HELD);
    // The first tick after a clear covers only part of a microsecond, so
    // release waits for HOLD_TO_US whole ticks after it.
    assign timeout_hit = (state_q == ST_HELD) && tick && (to_cnt_q == TO_LIMIT);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            addr_q    <= '0;
            key_vld_q <= 1'b0;
            key_rpt_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            rpt_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            addr_q    <= addr_d;
            key_vld_q <= key_vld_d;
            key_rpt_q <= key_rpt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Next-state logic: a valid frame always (re)enters HELD; a rejected frame
    // or an expired hold timer drops back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (press) begin
                    state_d = ST_HELD;
                end else if (bad || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and counter logic: key latching, event strobes, repeat gating,
    // error counting and the saturating hold timer.
    always_comb begin
        key_d     = key_q;
        addr_d    = addr_q;
        key_vld_d = 1'b0;
        key_rpt_d = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        to_cnt_d  = to_cnt_q;

        if (press) begin
            key_d     = f_cmd;
            addr_d    = f_addr;
            key_vld_d = 1'b1;
            rpt_cnt_d = '0;
            to_cnt_d  = '0;
        end else if (bad) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            rpt_cnt_d = '0;
            to_cnt_d  = '0;
        end else if (rpt_hit) begin
            to_cnt_d = '0;
            if (rpt_cnt_q < RC_LIMIT) begin
                rpt_cnt_d = rpt_cnt_q + RC_W'(1);
            end else begin
                key_vld_d = 1'b1;
                key_rpt_d = 1'b1;
            end
        end else if (state_q == ST_HELD) begin
            if (timeout_hit) begin
                to_cnt_d  = '0;
                rpt_cnt_d = '0;
            end else if (tick && (to_cnt_q != TO_LIMIT)) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    assign bus.o_key     = key_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_key_vld = key_vld_q;
    assign bus.o_key_rpt = key_rpt_q;
    assign bus.o_held    = (state_q == ST_HELD);
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ir_key_dec.sv
// Directed bench for ir_key_dec. Two instances share the stimulus: dut0 with
// no address filter, dut1 filtering on address 8'h00. Timing is scaled down
// (4 clk per tick, 50-tick hold timeout) to keep the run short.
`timescale 1ns/1ps
module tb_ir_key_dec;
    localparam int TDIV  = 4;
    localparam int HOLD  = 50;
    localparam int RDLY  = 3;
    localparam int TO_CY = HOLD * TDIV;

    localparam logic [31:0] F_16  = 32'h00FF_16E9;
    localparam logic [31:0] F_BAD = 32'h00FF_16E8;
    localparam logic [31:0] F_45  = 32'h00FF_45BA;
    localparam logic [31:0] F_0C  = 32'h00FF_0CF3;
    localparam logic [31:0] F_A01 = 32'h01FE_16E9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #10 clk = ~clk;

    ir_key_dec_if b0 ();
    ir_key_dec_if b1 ();

    ir_key_dec #(
        .TICK_DIV(TDIV), .HOLD_TO_US(HOLD), .RPT_DELAY(RDLY),
        .ADDR_FILT(1'b0), .ADDR(8'h00)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    ir_key_dec #(
        .TICK_DIV(TDIV), .HOLD_TO_US(HOLD), .RPT_DELAY(RDLY),
        .ADDR_FILT(1'b1), .ADDR(8'h00)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one cycle of strobes to both DUTs; returns #1 after the
    // sampling edge so the registered response is visible.
    task automatic drive(input logic [31:0] f, input logic fv, input logic r);
        @(negedge clk);
        b0.i_frame = f; b0.i_frame_vld = fv; b0.i_rpt = r;
        b1.i_frame = f; b1.i_frame_vld = fv; b1.i_rpt = r;
        @(posedge clk);
        #1;
        b0.i_frame_vld = 1'b0; b0.i_rpt = 1'b0;
        b1.i_frame_vld = 1'b0; b1.i_rpt = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_evt;
        b0.i_frame = '0; b0.i_frame_vld = 1'b0; b0.i_rpt = 1'b0;
        b1.i_frame = '0; b1.i_frame_vld = 1'b0; b1.i_rpt = 1'b0;

        // Reset state.
        idle(3);
        check("rst_key",     b0.o_key,     8'h00);
        check("rst_addr",    b0.o_addr,    8'h00);
        check("rst_vld",     b0.o_key_vld, 1'b0);
        check("rst_rpt",     b0.o_key_rpt, 1'b0);
        check("rst_held",    b0.o_held,    1'b0);
        check("rst_err",     b0.o_err,     1'b0);
        check("rst_err_cnt", b0.o_err_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Valid press.
        drive(F_16, 1'b1, 1'b0);
        check("press_vld",  b0.o_key_vld, 1'b1);
        check("press_rpt",  b0.o_key_rpt, 1'b0);
        check("press_key",  b0.o_key,     8'h16);
        check("press_addr", b0.o_addr,    8'h00);
        check("press_held", b0.o_held,    1'b1);
        idle(1);
        check("press_vld_1cyc", b0.o_key_vld, 1'b0);

        // Complement error while held: drops to IDLE, key kept.
        drive(F_BAD, 1'b1, 1'b0);
        check("cerr_err",     b0.o_err,     1'b1);
        check("cerr_cnt",     b0.o_err_cnt, 8'd1);
        check("cerr_vld",     b0.o_key_vld, 1'b0);
        check("cerr_held",    b0.o_held,    1'b0);
        check("cerr_key",     b0.o_key,     8'h16);
        idle(1);
        check("cerr_err_1cyc", b0.o_err,    1'b0);

        // Repeat with no key held is ignored.
        drive(32'h0, 1'b0, 1'b1);
        check("idle_rpt_vld", b0.o_key_vld, 1'b0);

        // Auto-repeat: repeats 1..3 swallowed, 4..6 produce events.
        drive(F_45, 1'b1, 1'b0);
        check("ar_press_key", b0.o_key, 8'h45);
        for (int i = 1; i <= 6; i++) begin
            idle(29);
            drive(32'h0, 1'b0, 1'b1);
            check($sformatf("ar_vld_%0d", i), b0.o_key_vld, (i > RDLY) ? 1'b1 : 1'b0);
            check($sformatf("ar_rpt_%0d", i), b0.o_key_rpt, (i > RDLY) ? 1'b1 : 1'b0);
        end
        check("ar_key",  b0.o_key,  8'h45);
        check("ar_held", b0.o_held, 1'b1);

        // Frame and repeat together while held: only the frame is seen,
        // and it restarts the repeat delay.
        drive(F_0C, 1'b1, 1'b1);
        check("both_vld", b0.o_key_vld, 1'b1);
        check("both_rpt", b0.o_key_rpt, 1'b0);
        check("both_key", b0.o_key,     8'h0C);
        check("both_f_vld", b1.o_key_vld, 1'b1);
        check("both_f_rpt", b1.o_key_rpt, 1'b0);
        drive(32'h0, 1'b0, 1'b1);
        check("both_next_rpt_vld", b0.o_key_vld, 1'b0);

        // Hold timeout: release within [HOLD, HOLD+1] ticks of the press.
        drive(F_16, 1'b1, 1'b0);
        n_evt = 0;
        for (int i = 0; i < TO_CY; i++) begin
            idle(1);
            n_evt += int'(b0.o_key_vld);
        end
        check("to_held_before", b0.o_held, 1'b1);
        for (int i = 0; i < TDIV; i++) begin
            idle(1);
            n_evt += int'(b0.o_key_vld);
        end
        check("to_held_after", b0.o_held, 1'b0);
        check("to_no_event",   n_evt,     0);
        drive(32'h0, 1'b0, 1'b1);
        check("to_rpt_vld",  b0.o_key_vld, 1'b0);
        check("to_rpt_held", b0.o_held,    1'b0);

        // Address filter: dut1 rejects address 01, dut0 accepts it.
        drive(F_A01, 1'b1, 1'b0);
        check("af_err",      b1.o_err,     1'b1);
        check("af_vld",      b1.o_key_vld, 1'b0);
        check("af_held",     b1.o_held,    1'b0);
        check("af_err_cnt",  b1.o_err_cnt, 8'd2);
        check("nf_vld",      b0.o_key_vld, 1'b1);
        check("nf_addr",     b0.o_addr,    8'h01);
        drive(F_16, 1'b1, 1'b0);
        check("af_ok_vld",   b1.o_key_vld, 1'b1);
        check("af_ok_held",  b1.o_held,    1'b1);
        check("af_ok_key",   b1.o_key,     8'h16);

        // Asynchronous reset while held.
        #3;
        rst = 1'b1;
        #1;
        check("arst_held",    b0.o_held,    1'b0);
        check("arst_key",     b0.o_key,     8'h00);
        check("arst_addr",    b0.o_addr,    8'h00);
        check("arst_err_cnt", b0.o_err_cnt, 8'h00);
        check("arst_f_held",  b1.o_held,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b1);
        check("arst_rpt_vld", b0.o_key_vld, 1'b0);

        // Error counter saturation.
        for (int i = 1; i <= 300; i++) begin
            drive(F_BAD, 1'b1, 1'b0);
            if (i == 1)   check("sat_cnt_1",   b0.o_err_cnt, 8'd1);
            if (i == 254) check("sat_cnt_254", b0.o_err_cnt, 8'd254);
        end
        check("sat_err",  b0.o_err,     1'b1);
        check("sat_cnt",  b0.o_err_cnt, 8'd255);
        check("sat_fcnt", b1.o_err_cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
